// File: rtl/demux_116_tdm_if.sv
// Serial slot bus into the 16-channel TDM demux and its parallel frame output.
// master drives the slot stream, slave is the demux.
interface demux_116_tdm_if;
   logic        i;
   logic        i_valid;
   logic        sync;
   logic [15:0] o;
   logic [3:0]  ch;
   logic        locked;
   logic        frame_done;
   logic        sync_err;

   modport master (
      output i, i_valid, sync,
      input  o, ch, locked, frame_done, sync_err
   );

   modport slave (
      input  i, i_valid, sync,
      output o, ch, locked, frame_done, sync_err
   );
endinterface

// File: rtl/demux_116_tdm.sv
// Time-division 1-to-16 demux: collects one bit per slot into a shadow
// register, locked to a frame marker, and publishes whole frames atomically.
module demux_116_tdm (
   input logic clk,
   input logic rst,
   demux_116_tdm_if.slave bus
);
   typedef enum logic {HUNT, LOCK} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [14:0] r_shadow;
   logic [15:0] r_o;
   logic        r_locked;
   logic        r_frame_done;
   logic        r_sync_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= HUNT;
         r_cnt        <= 4'd0;
         r_shadow     <= 15'd0;
         r_o          <= 16'd0;
         r_locked     <= 1'b0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
         if (bus.i_valid) begin
            unique case (r_state)
               HUNT: begin
                  if (bus.sync) begin
                     r_shadow[0] <= bus.i;
                     r_cnt       <= 4'd1;
                     r_state     <= LOCK;
                     r_locked    <= 1'b1;
                  end else begin
                     r_cnt <= 4'd0;
                  end
               end
               LOCK: begin
                  // A marker always restarts the frame at channel 0.
                  if (bus.sync) begin
                     r_sync_err  <= (r_cnt != 4'd0);
                     r_shadow[0] <= bus.i;
                     r_cnt       <= 4'd1;
                  end else if (r_cnt == 4'd0) begin
                     r_sync_err <= 1'b1;
                     r_state    <= HUNT;
                     r_locked   <= 1'b0;
                  end else if (r_cnt == 4'd15) begin
                     r_o          <= {bus.i, r_shadow};
                     r_frame_done <= 1'b1;
                     r_cnt        <= 4'd0;
                  end else begin
                     for (int n = 1; n < 15; n++) begin
                        if (r_cnt == 4'(n)) r_shadow[n] <= bus.i;
                     end
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

   assign bus.o          = r_o;
   assign bus.ch         = r_cnt;
   assign bus.locked     = r_locked;
   assign bus.frame_done = r_frame_done;
   assign bus.sync_err   = r_sync_err;
endmodule
